// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory line-transfer arbiter.
//   arb_state_e : transfer FSM states
//   owner_e     : grant owner encoding (IC=0, DC=1)
//   BEAT_BYTES  : bytes per memory beat (one DATA_W word)
package cache_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int unsigned BEAT_BYTES = 4;

endpackage

// File: rtl/arb_pick2.sv
// Two-way tie-break between icache and dcache requests.
//   req_ic, req_dc : pending requests
//   last_grant     : owner granted most recently
//   winner         : owner to grant (only meaningful when a request is pending)
// Optional macro ARB_DCACHE_PRIO_EN: dcache wins every tie instead of
// alternating with the last grant.
module arb_pick2
  import cache_arb_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  owner_e last_grant,
  output owner_e winner
);

  always_comb begin
    winner = OWN_IC;
    if (req_ic && req_dc) begin
`ifdef ARB_DCACHE_PRIO_EN
      winner = OWN_DC;
`else
      winner = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
`endif
    end else if (req_dc) begin
      winner = OWN_DC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto a single
// memory port, one full cache line per grant, one beat outstanding.
//   clk, rst                          : clock, synchronous active-high reset
//   ic_req/ic_addr                    : icache refill request and miss address
//   ic_rvalid/ic_rdata/ic_done        : icache refill data strobe and end pulse
//   dc_req/dc_we/dc_addr/dc_wdata     : dcache request (we=1 writeback)
//   dc_wnext                          : current writeback word consumed
//   dc_rvalid/dc_rdata/dc_done        : dcache refill data strobe and end pulse
//   m_req/m_we/m_addr/m_wdata/m_ready : memory beat request handshake
//   m_rvalid/m_rdata                  : memory read data return
// Optional macro ARB_DCACHE_PRIO_EN: dcache wins every simultaneous request.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFS_W = $clog2(LINE_WORDS * BEAT_BYTES);
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFS_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q,  last_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  owner_e            pick;

  arb_pick2 u_pick (
    .req_ic    (ic_req),
    .req_dc    (dc_req),
    .last_grant(last_q),
    .winner    (pick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    base_d  = base_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d = pick;
          we_d    = (pick == OWN_DC) && dc_we;
          base_d  = ((pick == OWN_DC) ? dc_addr : ic_addr) & BASE_MASK;
          count_d = '0;
          state_d = ((pick == OWN_DC) && dc_we) ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (m_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (m_rvalid) begin
          count_d = count_q + CNT_W'(1);
          state_d = (count_q == LAST_BEAT) ? S_DONE : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (m_ready) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IC;
      last_q  <= OWN_DC;
      we_q    <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

  // Outputs decode the registered state; rst forces them low in the reset
  // cycle so an abandoned transfer cannot emit a beat or forward data.
  logic active, fwd;
  assign active = !rst;
  assign fwd    = active && (state_q == S_RD_WAIT) && m_rvalid;

  always_comb begin
    m_req     = active && ((state_q == S_RD_REQ) || (state_q == S_WR_REQ));
    m_we      = active && (state_q == S_WR_REQ);
    m_addr    = m_req ? (base_q + ADDR_W'(count_q) * ADDR_W'(BEAT_BYTES)) : '0;
    m_wdata   = m_we ? dc_wdata : '0;
    dc_wnext  = m_we && m_ready;
    ic_rvalid = fwd && (owner_q == OWN_IC);
    dc_rvalid = fwd && (owner_q == OWN_DC);
    ic_rdata  = ic_rvalid ? m_rdata : '0;
    dc_rdata  = dc_rvalid ? m_rdata : '0;
    ic_done   = active && (state_q == S_DONE) && (owner_q == OWN_IC);
    dc_done   = active && (state_q == S_DONE) && (owner_q == OWN_DC);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int K_BRD  = 1;
  localparam int K_BWR  = 2;
  localparam int K_ICRD = 3;
  localparam int K_DCRD = 4;
  localparam int K_ICD  = 5;
  localparam int K_DCD  = 6;
  localparam int IC = 0;
  localparam int DC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done;
  logic [31:0] ic_rdata, dc_rdata;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = 32'hD000_0000;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  bit  ready_mode = 1'b0;  // 0: m_ready always high, 1: every other cycle
  bit  spur = 1'b0;        // inject m_ready/m_rvalid regardless of traffic

  cache_mem_arbiter #(.LINE_WORDS(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_done(dc_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void push(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  function automatic void push_refill(int who, logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      push(K_BRD, base + 32'(4 * i), 32'h0);
      push(who == IC ? K_ICRD : K_DCRD, 32'h0, rd_val(base + 32'(4 * i)));
    end
    push(who == IC ? K_ICD : K_DCD, 32'h0, 32'h0);
  endfunction

  function automatic void push_write(logic [31:0] base);
    for (int i = 0; i < 16; i++)
      push(K_BWR, base + 32'(4 * i), 32'hD000_0000 + 32'(i));
    push(K_DCD, 32'h0, 32'h0);
  endfunction

  function automatic void got_event(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h required none", k, a, d);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", 32'(k), 32'(e.kind));
      if (e.kind == K_BRD || e.kind == K_BWR) chk("beat_addr", a, e.addr);
      if (e.kind != K_ICD && e.kind != K_DCD) chk("ev_data", d, e.data);
    end
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'h0);
    chk("rst_ic_rvalid", 32'(ic_rvalid), 32'h0);
    chk("rst_dc_done", 32'(dc_done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Requesters drop their request on done; ends when both are low.
  task automatic wait_idle(int budget);
    int n = 0;
    while ((ic_req || dc_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (ic_done) begin @(posedge clk); #1; ic_req = 1'b0; end
      else if (dc_done) begin @(posedge clk); #1; dc_req = 1'b0; end
    end
    if (ic_req || dc_req) begin
      chk("transfer_timeout", 32'(n), 32'(budget + 1));
      ic_req = 1'b0; dc_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    fork
      // Monitor: every DUT output event pops and checks the scoreboard.
      forever begin
        @(negedge clk);
        if (m_req && m_ready) begin
          got_event(m_we ? K_BWR : K_BRD, m_addr, m_wdata);
          if (m_we) chk("wnext_on_accept", 32'(dc_wnext), 32'h1);
        end
        if (dc_wnext && !(m_req && m_we && m_ready)) begin
          total++; bad++;
          $display("FAIL wnext_stray: got 1 required 0");
        end
        if (ic_rvalid) got_event(K_ICRD, 32'h0, ic_rdata);
        if (dc_rvalid) got_event(K_DCRD, 32'h0, dc_rdata);
        if (ic_done)   got_event(K_ICD, 32'h0, 32'h0);
        if (dc_done)   got_event(K_DCD, 32'h0, 32'h0);
      end
      // Memory and dcache writeback-source model.
      begin
        logic        acc, wn, dd, ph;
        logic [31:0] acc_addr;
        int          widx;
        ph = 1'b0; widx = 0;
        forever begin
          @(negedge clk);
          acc = m_req && m_ready && !m_we;
          acc_addr = m_addr;
          wn = dc_wnext;
          dd = dc_done;
          @(posedge clk); #1;
          m_rvalid = acc;
          m_rdata  = acc ? rd_val(acc_addr) : 32'hDEAD_BEEF;
          ph = ~ph;
          m_ready  = ready_mode ? ph : 1'b1;
          if (spur) begin
            m_rvalid = 1'b1; m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0;
          end
          if (dd) widx = 0;
          else if (wn) widx++;
          dc_wdata = 32'hD000_0000 + 32'(widx);
        end
      end
    join_none

    do_reset();
    @(negedge clk);
    chk("idle_m_req", 32'(m_req), 32'h0);
    chk("idle_m_addr", m_addr, 32'h0);
    chk("idle_ic_done", 32'(ic_done), 32'h0);

    // icache refill, unaligned address
    push_refill(IC, 32'h0000_1200);
    @(posedge clk); #1; ic_addr = 32'h0000_1234; ic_req = 1'b1;
    wait_idle(400);

    // dcache writeback with m_ready every other cycle
    ready_mode = 1'b1;
    push_write(32'h0000_8040);
    @(posedge clk); #1; dc_addr = 32'h0000_8040; dc_we = 1'b1; dc_req = 1'b1;
    wait_idle(400);
    ready_mode = 1'b0;
    dc_we = 1'b0;

    // spurious handshakes in IDLE must not be forwarded or counted
    @(posedge clk); #1; spur = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("spur_ic_rvalid", 32'(ic_rvalid), 32'h0);
      chk("spur_dc_rvalid", 32'(dc_rvalid), 32'h0);
      chk("spur_m_req", 32'(m_req), 32'h0);
    end
    @(posedge clk); #1; spur = 1'b0;
    @(posedge clk); #1;
    push_refill(IC, 32'h0000_3000);
    ic_addr = 32'h0000_3008; ic_req = 1'b1;
    wait_idle(400);

    // simultaneous requests after reset
    do_reset();
`ifdef ARB_DCACHE_PRIO_EN
    push_refill(DC, 32'h0000_2000);
    push_refill(IC, 32'h0000_1000);
`else
    push_refill(IC, 32'h0000_1000);
    push_refill(DC, 32'h0000_2000);
`endif
    @(posedge clk); #1;
    ic_addr = 32'h0000_1000; ic_req = 1'b1;
    dc_addr = 32'h0000_2000; dc_we = 1'b0; dc_req = 1'b1;
    wait_idle(800);

    // icache alone, then a tie: round-robin now favours dcache
    push_refill(IC, 32'h0000_1100);
    @(posedge clk); #1; ic_addr = 32'h0000_1100; ic_req = 1'b1;
    wait_idle(400);
    push_refill(DC, 32'h0000_2800);
    push_refill(IC, 32'h0000_1400);
    @(posedge clk); #1;
    ic_addr = 32'h0000_1400; ic_req = 1'b1;
    dc_addr = 32'h0000_2800; dc_req = 1'b1;
    wait_idle(800);

    // reset while beat 5 of a refill is being requested
    for (int i = 0; i < 5; i++) begin
      push(K_BRD, 32'h0000_4000 + 32'(4 * i), 32'h0);
      push(K_ICRD, 32'h0, rd_val(32'h0000_4000 + 32'(4 * i)));
    end
    @(posedge clk); #1; ic_addr = 32'h0000_4010; ic_req = 1'b1;
    begin
      int seen = 0;
      int n = 0;
      while (seen < 5 && n < 200) begin
        @(negedge clk);
        n++;
        if (ic_rvalid) seen++;
      end
      chk("beats_before_rst", 32'(seen), 32'h5);
    end
    @(posedge clk); #1; rst = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    chk("midrst_m_req", 32'(m_req), 32'h0);
    chk("midrst_m_addr", m_addr, 32'h0);
    chk("midrst_ic_rvalid", 32'(ic_rvalid), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_ic_done", 32'(ic_done), 32'h0);
      chk("post_rst_m_req", 32'(m_req), 32'h0);
    end
    chk("abandoned_sb_drained", 32'(sb.size()), 32'h0);
    push_refill(IC, 32'h0000_4000);
    @(posedge clk); #1; ic_req = 1'b1;
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
